// File: rtl/button_hold_repeat.sv
// Debounced push-button front end: synchronizer, debounce counter, and a
// short/long/auto-repeat press classifier producing single-cycle event pulses.
module button_hold_repeat #(
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter int DEBOUNCE_TICKS   = 655,
    parameter int LONG_PRESS_TICKS = 16384,
    parameter int REPEAT_TICKS     = 4096
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Button,
    output logic o_Held,
    output logic o_Pressed_Short,
    output logic o_Pressed_Long,
    output logic o_Repeat,
    output logic o_Released
);
    localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_MAX = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
    localparam int HC_W     = $clog2(HOLD_MAX + 1);

    // The released pin level coincides with ACTIVE_LOW (1 for active-low pins).
    localparam logic            RELEASED  = ACTIVE_LOW;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HC_W-1:0] LONG_LAST = HC_W'(LONG_PRESS_TICKS - 1);
    localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_TICKS - 1);
    localparam logic [HC_W-1:0] HC_MAX    = '1;

    typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

    logic            sync_meta, sync_out;
    logic            pressed;
    logic [DB_W-1:0] db_cnt;
    logic            held;
    logic            toggle, rise, fall;

    state_t          state, state_next;
    logic [HC_W-1:0] hold_cnt, hold_cnt_next;
    logic            short_next, long_next, rep_next, rel_next;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_meta <= RELEASED;
            sync_out  <= RELEASED;
        end else begin
            sync_meta <= i_Button;
            sync_out  <= sync_meta;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync_out : sync_out;

    // Toggle on the edge where the mismatch run would reach DEBOUNCE_TICKS.
    assign toggle = (pressed != held) && (db_cnt == DB_LAST);
    assign rise   = toggle & ~held;
    assign fall   = toggle & held;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            db_cnt <= '0;
            held   <= 1'b0;
        end else if (pressed == held) begin
            db_cnt <= '0;
        end else if (toggle) begin
            db_cnt <= '0;
            held   <= ~held;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        short_next    = 1'b0;
        long_next     = 1'b0;
        rep_next      = 1'b0;
        rel_next      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next    = SHORT;
                    hold_cnt_next = '0;
                end
            end
            SHORT: begin
                // Release outranks the long threshold landing on the same edge.
                if (fall) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                    short_next    = 1'b1;
                    rel_next      = 1'b1;
                end else if (hold_cnt == LONG_LAST) begin
                    state_next    = LONG;
                    hold_cnt_next = '0;
                    long_next     = 1'b1;
                    rep_next      = 1'b1;
                end else if (hold_cnt != HC_MAX) begin
                    hold_cnt_next = hold_cnt + HC_W'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                    rel_next      = 1'b1;
                end else if (hold_cnt == REP_LAST) begin
                    hold_cnt_next = '0;
                    rep_next      = 1'b1;
                end else if (hold_cnt != HC_MAX) begin
                    hold_cnt_next = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            o_Pressed_Short <= 1'b0;
            o_Pressed_Long  <= 1'b0;
            o_Repeat        <= 1'b0;
            o_Released      <= 1'b0;
        end else begin
            state           <= state_next;
            hold_cnt        <= hold_cnt_next;
            o_Pressed_Short <= short_next;
            o_Pressed_Long  <= long_next;
            o_Repeat        <= rep_next;
            o_Released      <= rel_next;
        end
    end

    assign o_Held = held;
endmodule

// File: doc/button_hold_repeat.md
# button_hold_repeat

Debounced button front end with short-press, long-press and auto-repeat detection. It sits between a raw board push-button pin and the control logic, in the same clock domain as the debouncers (`i_Clock`, about 32.7 kHz from the prescaler). It produces single-cycle event pulses so that holding the Up button auto-increments the counters, and a long press on Set can be decoded separately from a short press.

## Interface
Parameters:
- ACTIVE_LOW, 1: 1 means the raw pin reads 0 when pressed.
- DEBOUNCE_TICKS, 655: consecutive cycles the synchronized input must differ from the stable state before that state flips (about 20 ms). Legal range is ≥1.
- LONG_PRESS_TICKS, 16384: hold cycles from the debounced press to the long-press event (about 0.5 s). Legal range is ≥2.
- REPEAT_TICKS, 4096: cycles between auto-repeat pulses after the long-press point (about 125 ms). Legal range is ≥1.

Ports:
- i_Clock, input, 1: single clock; all logic is on the rising edge.
- i_Reset, input, 1: asynchronous, active-high reset.
- i_Button, input, 1: raw, asynchronous button pin.
- o_Held, output, 1: debounced level; 1 while the button is considered pressed.
- o_Pressed_Short, output, 1: one-cycle pulse on a release that occurs before the long-press point.
- o_Pressed_Long, output, 1: one-cycle pulse when a hold reaches LONG_PRESS_TICKS.
- o_Repeat, output, 1: one-cycle pulse at the long-press point, then every REPEAT_TICKS while held.
- o_Released, output, 1: one-cycle pulse on every debounced release.

## Operation
- Input stage: a 2-FF synchronizer. Its output is normalized to `pressed = ACTIVE_LOW ? ~sync : sync`.
- Debounce:
  - A counter of width $clog2(DEBOUNCE_TICKS+1) increments while `pressed != o_Held` and clears in any cycle where they are equal.
  - When the counter reaches DEBOUNCE_TICKS, o_Held toggles and the counter clears.
- Hold counter:
  - Width is $clog2(max(LONG_PRESS_TICKS, REPEAT_TICKS)+1).
  - It clears on the o_Held rising edge and increments each cycle while held.
  - It is reused for repeat spacing and cleared at each repeat pulse. It never wraps.
- FSM states: IDLE, SHORT, LONG.
  - IDLE → SHORT on o_Held rising; the hold counter is 0 in the first SHORT cycle.
  - SHORT → LONG when the hold counter reaches LONG_PRESS_TICKS−1 while still held. That cycle's registered outputs are o_Pressed_Long=1 and o_Repeat=1, and the counter clears.
  - SHORT → IDLE on o_Held falling: o_Pressed_Short=1 and o_Released=1.
  - In LONG, when the counter reaches REPEAT_TICKS−1: o_Repeat=1 and the counter clears.
  - LONG → IDLE on o_Held falling: o_Released=1 only, with no short pulse and no repeat that cycle.
- Simultaneous events:
  - If the release and the long threshold land in the same cycle, the release wins. The block emits a short press, no long press and no repeat.
  - If the release and a repeat threshold coincide, only o_Released fires.
- All pulse outputs are registered and are 0 in every cycle not listed above. The pulses are mutually consistent: o_Pressed_Short and o_Pressed_Long never both fire in one press.
- Reset (asynchronous, any time including mid-hold):
  - State goes to IDLE and all counters clear.
  - o_Held, o_Pressed_Short, o_Pressed_Long, o_Repeat and o_Released are all 0.
  - The synchronizer FFs load the released level (1 if ACTIVE_LOW, else 0).
  - No event is emitted for a press that was interrupted by reset.
  - A button still held after reset deasserts is debounced as a fresh press.

## Timing
- Press latency: o_Held rises DEBOUNCE_TICKS+2 edges after the first edge that samples a stable pressed pin (2 synchronizer edges plus DEBOUNCE_TICKS counting edges).
- Release latency to o_Held falling, o_Released and o_Pressed_Short is the same, DEBOUNCE_TICKS+2 edges. Those three change on the same edge.
- o_Pressed_Long and the first o_Repeat fire LONG_PRESS_TICKS edges after o_Held rises.
- Subsequent o_Repeat pulses are spaced exactly REPEAT_TICKS edges apart.
- Glitches shorter than DEBOUNCE_TICKS cycles (after synchronization) produce no output change.
- No combinational path from i_Button to any output.

## Test plan
Bench parameters: ACTIVE_LOW=1, DEBOUNCE_TICKS=4, LONG_PRESS_TICKS=20, REPEAT_TICKS=8.

- Reset asserted with i_Button=0 → all outputs 0. After deassert, o_Held rises exactly 6 edges after the first sampled low.
- Glitch: i_Button low for 3 cycles, then high → o_Held stays 0 and no pulses occur.
- Short press: hold low for 12 cycles past o_Held rising, then release → after 6 edges, o_Held=0 with a single o_Pressed_Short and o_Released pulse on that edge. No o_Repeat or o_Pressed_Long.
- Long hold: hold for 45 cycles past o_Held rising → o_Pressed_Long and o_Repeat at cycle +20, o_Repeat again at +28 and +36, then release gives o_Released only.
- Boundary: arrange the debounced release so it lands on the cycle the hold counter hits 19 → o_Pressed_Short=1, o_Pressed_Long=0, o_Repeat=0.
- Reset mid-LONG with i_Button held low → outputs clear asynchronously. After deassert, a new press is detected 6 edges later, with no stale repeat or release pulse.
